fetch_ctrl: RTL and testbench

Sequencing controller for the instruction-fetch stage.
- Owns the PC register and drives the fetch address into the IF block (PC+4 adder plus instruction ROM).
- Consumes the IF adder's `pc+4` result and the ROM word returned under a req/ack handshake, so ROM latency may vary.
- Presents instructions to decode through a valid/stall interface backed by a one-entry skid buffer.
- Applies branch/jump redirects, flushing wrong-path instructions.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_skid.sv | 46 ++++
 rtl/fetch_ctrl.sv | 168 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Fetch FSM states, the {inst, pc} pair held by the skid buffer, and the word-align helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_word_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding an {inst, pc} pair while decode is stalled.
// Flush has priority over push/pop; push and pop may occur in the same cycle.
module fetch_skid
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  fetch_word_t din,
  output fetch_word_t dout,
  output logic        full
);

  fetch_word_t data_q, data_d;
  logic        full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (flush) begin
      full_d = 1'b0;
    end else begin
      if (pop) full_d = 1'b0;
      if (push) begin
        full_d = 1'b1;
        data_d = din;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign dout = data_q;
  assign full = full_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the ROM req/ack handshake and feeds decode.
// Optional macro ALIGN_CHK_EN: misaligned redirects are ignored and flagged on misalign_err.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          AW       = 32
) (
  input  logic          clk,
  input  logic          clrn,
  output logic [AW-1:0] pc,
  input  logic [AW-1:0] pc_plus4,
  output logic          mem_req,
  input  logic          mem_ack,
  input  logic [31:0]   inst_in,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  input  logic          stall,
  output logic          inst_valid,
  output logic [31:0]   inst_out,
  output logic [AW-1:0] inst_pc
`ifdef ALIGN_CHK_EN
  ,
  output logic          misalign_err
`endif
);

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [AW-1:0]   pend_pc_q, pend_pc_d;
  logic            in_flight_q, in_flight_d;
  logic            inst_valid_q, inst_valid_d;
  logic [31:0]     inst_out_q, inst_out_d;
  logic [AW-1:0]   inst_pc_q, inst_pc_d;

  logic            redir, ack_v, consume, accept;
  logic [AW-1:0]   redir_tgt;
  logic            skid_push, skid_pop, skid_flush, skid_full;
  fetch_word_t     skid_din, skid_dout;

`ifdef ALIGN_CHK_EN
  logic            misaligned;
  logic            misalign_err_q, misalign_err_d;
  assign misaligned   = redirect & (redirect_pc[1:0] != 2'b00);
  assign redir        = redirect & ~misaligned;
  assign misalign_err = misalign_err_q;
`else
  assign redir = redirect;
`endif

  assign redir_tgt = word_align(redirect_pc);
  assign mem_req   = in_flight_q | ((state_q == FETCH) & ~skid_full) | (state_q == DROP);
  // Acks are only meaningful against an issued request; stale acks in BOOT fall out here.
  assign ack_v     = mem_ack & mem_req;
  assign consume   = inst_valid_q & ~stall;
  assign skid_din  = '{inst: inst_in, pc: pc_q};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    in_flight_d  = mem_req & ~mem_ack;
    inst_valid_d = inst_valid_q;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
    skid_push    = 1'b0;
    skid_pop     = 1'b0;
    skid_flush   = 1'b0;
    accept       = 1'b0;
`ifdef ALIGN_CHK_EN
    misalign_err_d = misaligned;
`endif

    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (redir) pc_d = redir_tgt;
      end
      FETCH: begin
        if (redir) begin
          // A request already on the bus must drain before the pc can move.
          if (mem_req & ~mem_ack) begin
            pend_pc_d = redir_tgt;
            state_d   = DROP;
          end else begin
            pc_d = redir_tgt;
          end
        end else if (ack_v) begin
          accept = 1'b1;
          pc_d   = pc_plus4;
        end
      end
      DROP: begin
        if (redir) pend_pc_d = redir_tgt;
        if (ack_v) begin
          pc_d    = redir ? redir_tgt : pend_pc_q;
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase

    if (redir) begin
      inst_valid_d = 1'b0;
      skid_flush   = 1'b1;
    end else if (consume | ~inst_valid_q) begin
      if (skid_full) begin
        inst_valid_d = 1'b1;
        inst_out_d   = skid_dout.inst;
        inst_pc_d    = skid_dout.pc;
        skid_pop     = 1'b1;
        skid_push    = accept;
      end else if (accept) begin
        inst_valid_d = 1'b1;
        inst_out_d   = inst_in;
        inst_pc_d    = pc_q;
      end else begin
        inst_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_push = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      pend_pc_q    <= '0;
      in_flight_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_out_q   <= NOP;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      in_flight_q  <= in_flight_d;
      inst_valid_q <= inst_valid_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

`ifdef ALIGN_CHK_EN
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) misalign_err_q <= 1'b0;
    else       misalign_err_q <= misalign_err_d;
  end
`endif

  fetch_skid u_skid (
    .clk   (clk),
    .clrn  (clrn),
    .push  (skid_push),
    .pop   (skid_pop),
    .flush (skid_flush),
    .din   (skid_din),
    .dout  (skid_dout),
    .full  (skid_full)
  );

  assign pc         = pc_q;
  assign inst_valid = inst_valid_q;
  assign inst_out   = inst_out_q;
  assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a ROM model with variable latency, an expected program-order
// stream restarted on every accepted redirect, and a monitor checking each consumed instruction.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic [31:0] pc, pc_plus4, inst_out, inst_pc;
  logic [31:0] inst_in = '0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req, inst_valid;
  logic        mem_ack = 1'b0;
  logic        redirect = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_eff;
`ifdef ALIGN_CHK_EN
  logic        misalign_err;
  assign redirect_eff = redirect && (redirect_pc[1:0] == 2'b00);
`else
  assign redirect_eff = redirect;
`endif

  int n_checks = 0, n_errors = 0, n_consumed = 0;
  int lat_fix = 0;
  bit rom_en = 1'b1;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;
  assign pc_plus4 = pc + 32'd4;   // IF adder, wraps naturally

  fetch_ctrl #(.RESET_PC(32'h0), .AW(32)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .inst_in     (inst_in),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .inst_valid  (inst_valid),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc)
`ifdef ALIGN_CHK_EN
    ,
    .misalign_err(misalign_err)
`endif
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic bit tgt_accepted(input logic [31:0] t);
`ifdef ALIGN_CHK_EN
    return t[1:0] == 2'b00;
`else
    return 1'b1;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_restart(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(start + 32'(i * 4));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redirect    = 1'b1;
    redirect_pc = tgt;
    if (tgt_accepted(tgt)) sb_restart(word_align(tgt));
    tick();
    redirect = 1'b0;
  endtask

  task automatic do_reset();
    clrn     = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    sb_restart(32'h0);
    tick();
    tick();
    clrn = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int i;
    i = 0;
    while (!inst_valid && i < 20) begin
      tick();
      i++;
    end
    check(name, {31'b0, inst_valid}, 32'd1);
  endtask

  // ROM: latches pc when a request starts, answers after lat_fix (or random) cycles.
  initial begin : rom_proc
    logic [31:0] addr;
    int lat;
    bit busy;
    addr = '0; lat = 0; busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rom_en) begin
        busy = 1'b0;
        continue;
      end
      mem_ack = 1'b0;
      if (!clrn) begin
        busy = 1'b0;
        continue;
      end
      if (busy) begin
        check("req_hold", {31'b0, mem_req}, 32'd1);
        check("pc_stable", pc, addr);
      end else if (mem_req) begin
        busy = 1'b1;
        addr = pc;
        lat  = (lat_fix < 0) ? int'($urandom_range(0, 3)) : lat_fix;
      end
      if (busy) begin
        if (lat == 0) begin
          mem_ack = 1'b1;
          inst_in = rom_word(addr);
          busy    = 1'b0;
        end else begin
          lat--;
        end
      end
    end
  end

  // Monitor: pops the expected stream whenever decode consumes an instruction.
  initial begin : mon_proc
    logic [31:0] e;
    bit mis_prev;
    mis_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (clrn) begin
`ifdef ALIGN_CHK_EN
        check("misalign_err", {31'b0, misalign_err}, {31'b0, mis_prev});
        mis_prev = redirect && (redirect_pc[1:0] != 2'b00);
`endif
        if (inst_valid && !stall && !redirect_eff) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_empty: got inst_pc %h required no output", inst_pc);
          end else begin
            e = exp_q.pop_front();
            check("inst_pc", inst_pc, e);
            check("inst_out", inst_out, rom_word(e));
            n_consumed++;
            $display("consume pc=%h inst=%h exp_pc=%h", inst_pc, inst_out, e);
          end
        end
      end else begin
        mis_prev = 1'b0;
      end
    end
  end

  initial begin : stim
    int c0;
    logic [31:0] tgt;
    int since;

    // 1: reset values, then back-to-back acks
    lat_fix = 0;
    do_reset();
    clrn = 1'b0;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst_out", inst_out, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    #1;
    clrn = 1'b1;
    check("boot_mem_req", {31'b0, mem_req}, 32'd0);
    tick();
    check("t1_mem_req", {31'b0, mem_req}, 32'd1);
    check("t1_pc", pc, 32'h0);
    check("t1_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    check("t2_valid", {31'b0, inst_valid}, 32'd1);
    check("t2_inst_pc", inst_pc, 32'h0);
    check("t2_pc", pc, 32'h4);
    tick();
    check("t3_inst_pc", inst_pc, 32'h4);
    check("t3_pc", pc, 32'h8);
    tick();
    check("t4_inst_pc", inst_pc, 32'h8);
    check("t4_pc", pc, 32'hC);

    // 2: three-cycle ROM latency
    lat_fix = 3;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("lat_mem_req", {31'b0, mem_req}, 32'd1);
      check("lat_pc", pc, 32'h0);
      check("lat_valid", {31'b0, inst_valid}, 32'd0);
    end
    tick();
    check("lat_out_valid", {31'b0, inst_valid}, 32'd1);
    check("lat_out_pc", inst_pc, 32'h0);
    check("lat_next_pc", pc, 32'h4);
    tick();
    check("lat_no_dup", {31'b0, inst_valid}, 32'd0);

    // 3: stall with acks fills the skid and stops requests
    lat_fix = 0;
    do_reset();
    tick();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_mem_req", {31'b0, mem_req}, 32'd0);
      check("stall_hold_pc", inst_pc, 32'h0);
      check("stall_pc", pc, 32'h8);
    end
    c0 = n_consumed;
    stall = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("stall_drain", {31'b0, (n_consumed - c0) >= 4}, 32'd1);

    // 4: redirect while a request is outstanding
    lat_fix = 0;
    do_reset();
    tick();
    tick();
    lat_fix = 3;
    tick();
    tick();
    check("drop_pre_pc", pc, 32'h8);
    check("drop_pre_req", {31'b0, mem_req}, 32'd1);
    lat_fix = 0;
    do_redirect(32'h100);
    check("drop_hold_pc", pc, 32'h8);
    check("drop_flushed", {31'b0, inst_valid}, 32'd0);
    check("drop_req", {31'b0, mem_req}, 32'd1);
    tick();
    check("drop_hold_pc2", pc, 32'h8);
    tick();
    check("drop_new_pc", pc, 32'h100);
    check("drop_valid_low", {31'b0, inst_valid}, 32'd0);
    wait_valid("drop_wait");
    check("drop_first_pc", inst_pc, 32'h100);

    // 5: redirect coinciding with an ack
    do_reset();
    for (int i = 0; i < 20 && pc != 32'h10; i++) tick();
    check("ackredir_pc", pc, 32'h10);
    check("ackredir_ack", {31'b0, mem_ack}, 32'd1);
    do_redirect(32'h40);
    check("ackredir_new_pc", pc, 32'h40);
    check("ackredir_flush", {31'b0, inst_valid}, 32'd0);
    wait_valid("ackredir_wait");
    check("ackredir_first", inst_pc, 32'h40);

    // 6: misaligned redirect target
    for (int i = 0; i < 4; i++) tick();
    do_redirect(32'h42);
`ifdef ALIGN_CHK_EN
    check("mis_pulse", {31'b0, misalign_err}, 32'd1);
    tick();
    check("mis_pulse_end", {31'b0, misalign_err}, 32'd0);
`else
    wait_valid("mis_wait");
    check("mis_aligned_pc", inst_pc, 32'h40);
`endif
    for (int i = 0; i < 4; i++) tick();

    // 7: pc wrap at the top of the address space
    c0 = n_consumed;
    do_redirect(32'hFFFF_FFF8);
    for (int i = 0; i < 10; i++) tick();
    check("wrap_progress", {31'b0, (n_consumed - c0) >= 3}, 32'd1);

    // 8: async reset mid-operation, stale ack during BOOT
    check("pre_rst_pc_nonzero", {31'b0, pc != 32'h0}, 32'd1);
    rom_en  = 1'b0;
    mem_ack = 1'b0;
    clrn    = 1'b0;
    sb_restart(32'h0);
    #1;
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_req", {31'b0, mem_req}, 32'd0);
    check("async_rst_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    tick();
    clrn    = 1'b1;
    mem_ack = 1'b1;
    inst_in = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    check("stale_valid", {31'b0, inst_valid}, 32'd0);
    check("stale_pc", pc, 32'h0);
    lat_fix = 0;
    rom_en  = 1'b1;
    wait_valid("stale_wait");
    check("stale_first", inst_pc, 32'h0);

    // random traffic: latency, stall and redirects
    lat_fix = -1;
    c0 = n_consumed;
    since = 0;
    for (int n = 0; n < 2000; n++) begin
      stall = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 99) < 4 || since >= 150) begin
        tgt = $urandom;
        if (since >= 150 || $urandom_range(0, 1) == 1) tgt[1:0] = 2'b00;
        if (tgt_accepted(tgt)) since = 0;
        do_redirect(tgt);
      end else begin
        tick();
        since++;
      end
    end
    stall = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("random_liveness", {31'b0, (n_consumed - c0) >= 200}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
